// File: rtl/ex_ctrl_pipe_pkg.sv
// Shared widths and bundle bit positions for the execute-stage control delay line.
// Field order inside a bundle: single-bit enables at the bottom, then addr_rd, condcode, branchtrgt.
package ex_ctrl_pipe_pkg;

  localparam int REG_ADDR_WIDTH  = 5;
  localparam int COND_CODE_WIDTH = 4;
  localparam int IM_ADDR_WIDTH   = 10;

  localparam int EX_CTRL_WIDTH          = 6 + REG_ADDR_WIDTH + COND_CODE_WIDTH + IM_ADDR_WIDTH;
  localparam int EX_CTRL_PIPE_MAX_DEPTH = 8;

  localparam int BIT_DM_WE         = 0;
  localparam int BIT_DM_RE         = 1;
  localparam int BIT_RF_WE_W       = 2;
  localparam int BIT_RF_WE_UHW     = 3;
  localparam int BIT_BRANCHEN      = 4;
  localparam int BIT_SR_WE         = 5;
  localparam int LSB_ADDR_RD       = 6;
  localparam int LSB_CONDCODE      = LSB_ADDR_RD + REG_ADDR_WIDTH;
  localparam int LSB_BRANCHTRGT    = LSB_CONDCODE + COND_CODE_WIDTH;

endpackage

// File: rtl/ex_ctrl_stage.sv
// One stage of the control delay line: bundle register plus valid bit.
// Priority: reset, then flush (load bubble), then stall (hold), else capture.
module ex_ctrl_stage
  import ex_ctrl_pipe_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [EX_CTRL_WIDTH-1:0] ctrl_i,
  output logic                     valid_o,
  output logic [EX_CTRL_WIDTH-1:0] ctrl_o
);

  logic                     valid_d, valid_q;
  logic [EX_CTRL_WIDTH-1:0] ctrl_d, ctrl_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall_i) begin
      valid_d = valid_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/ex_ctrl_pipe.sv
// DEPTH-stage control delay line between decode and mem/writeback, with stall and flush.
// Optional forwarding/hazard taps are enabled with `EX_CTRL_PIPE_TAP_EN.
module ex_ctrl_pipe
  import ex_ctrl_pipe_pkg::*;
#(
  parameter int DEPTH = 3
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic                       dm_we_i,
  input  logic                       dm_re_i,
  input  logic [REG_ADDR_WIDTH-1:0]  addr_rd_i,
  input  logic                       regfile_we_w_i,
  input  logic                       regfile_we_uhw_i,
  input  logic                       branchen_i,
  input  logic [COND_CODE_WIDTH-1:0] condcode_i,
  input  logic [IM_ADDR_WIDTH-1:0]   branchtrgt_i,
  input  logic                       sr_we_i,
  output logic                       valid_o,
  output logic                       dm_we_o,
  output logic                       dm_re_o,
  output logic [REG_ADDR_WIDTH-1:0]  addr_rd_o,
  output logic                       regfile_we_w_o,
  output logic                       regfile_we_uhw_o,
  output logic                       branchen_o,
  output logic [COND_CODE_WIDTH-1:0] condcode_o,
  output logic [IM_ADDR_WIDTH-1:0]   branchtrgt_o,
  output logic                       sr_we_o
`ifdef EX_CTRL_PIPE_TAP_EN
  ,
  input  logic [REG_ADDR_WIDTH-1:0]        addr_rs_i,
  input  logic [REG_ADDR_WIDTH-1:0]        addr_rt_i,
  output logic [DEPTH-1:0]                 tap_valid_o,
  output logic [DEPTH-1:0]                 tap_rf_we_o,
  output logic [DEPTH*REG_ADDR_WIDTH-1:0]  tap_addr_rd_o,
  output logic                             hazard_o
`endif
);

  logic [EX_CTRL_WIDTH-1:0] ctrl_in;
  logic [DEPTH-1:0]         stg_valid;
  logic [EX_CTRL_WIDTH-1:0] stg_ctrl [DEPTH];
  logic [EX_CTRL_WIDTH-1:0] ctrl_out;

  // Bubbles carry no enables: the whole bundle is zeroed when valid_i is low.
  always_comb begin
    ctrl_in = '0;
    if (valid_i) begin
      ctrl_in[BIT_DM_WE]                              = dm_we_i;
      ctrl_in[BIT_DM_RE]                              = dm_re_i;
      ctrl_in[BIT_RF_WE_W]                            = regfile_we_w_i;
      ctrl_in[BIT_RF_WE_UHW]                          = regfile_we_uhw_i;
      ctrl_in[BIT_BRANCHEN]                           = branchen_i;
      ctrl_in[BIT_SR_WE]                              = sr_we_i;
      ctrl_in[LSB_ADDR_RD    +: REG_ADDR_WIDTH]       = addr_rd_i;
      ctrl_in[LSB_CONDCODE   +: COND_CODE_WIDTH]      = condcode_i;
      ctrl_in[LSB_BRANCHTRGT +: IM_ADDR_WIDTH]        = branchtrgt_i;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      ex_ctrl_stage u_stage (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ctrl_i  (ctrl_in),
        .valid_o (stg_valid[k]),
        .ctrl_o  (stg_ctrl[k])
      );
    end else begin : g_body
      ex_ctrl_stage u_stage (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_i),
        .flush_i (flush_i),
        .valid_i (stg_valid[k-1]),
        .ctrl_i  (stg_ctrl[k-1]),
        .valid_o (stg_valid[k]),
        .ctrl_o  (stg_ctrl[k])
      );
    end
  end

  assign ctrl_out         = stg_ctrl[DEPTH-1];
  assign valid_o          = stg_valid[DEPTH-1];
  assign dm_we_o          = ctrl_out[BIT_DM_WE];
  assign dm_re_o          = ctrl_out[BIT_DM_RE];
  assign regfile_we_w_o   = ctrl_out[BIT_RF_WE_W];
  assign regfile_we_uhw_o = ctrl_out[BIT_RF_WE_UHW];
  assign branchen_o       = ctrl_out[BIT_BRANCHEN];
  assign sr_we_o          = ctrl_out[BIT_SR_WE];
  assign addr_rd_o        = ctrl_out[LSB_ADDR_RD    +: REG_ADDR_WIDTH];
  assign condcode_o       = ctrl_out[LSB_CONDCODE   +: COND_CODE_WIDTH];
  assign branchtrgt_o     = ctrl_out[LSB_BRANCHTRGT +: IM_ADDR_WIDTH];

`ifdef EX_CTRL_PIPE_TAP_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    assign tap_rf_we_o[k] = stg_ctrl[k][BIT_RF_WE_W] | stg_ctrl[k][BIT_RF_WE_UHW];
    assign tap_addr_rd_o[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] =
      stg_ctrl[k][LSB_ADDR_RD +: REG_ADDR_WIDTH];
  end
  assign tap_valid_o = stg_valid;

  always_comb begin
    hazard_o = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_valid_o[k] && tap_rf_we_o[k] &&
          ((tap_addr_rd_o[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr_rs_i) ||
           (tap_addr_rd_o[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr_rt_i)))
        hazard_o = 1'b1;
    end
  end
`endif

endmodule
